// File: rtl/lvds_serial_tx_pkg.sv
// lvds_serial_tx_pkg: shared LVDS link constants and FSM state encodings (also reused by the receiver).
package lvds_serial_tx_pkg;
    localparam int LVDS_CH_NUM = 1;
    localparam logic LVDS_IDLE_LVL = 1'b1;
    localparam logic LVDS_START_LVL = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } lvds_state_e;
endpackage

// File: rtl/lvds_serial_tx_if.sv
// lvds_serial_tx_if: upstream-to-transmitter bundle; data_in/tx_ena request, tx line, tx_busy, tx_done.
interface lvds_serial_tx_if #(parameter int W = 8);
    logic [W-1:0] data_in;
    logic         tx_ena;
    logic         tx;
    logic         tx_busy;
    logic         tx_done;
    modport master (output data_in, tx_ena, input tx, tx_busy, tx_done);
    modport slave  (input data_in, tx_ena, output tx, tx_busy, tx_done);
endinterface

// File: rtl/lvds_bit_timer.sv
// lvds_bit_timer: holds each line bit CLKS_PER_BIT cycles; ports clk, rst, run in, bit_end out on last count.
module lvds_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt;
    // with CLKS_PER_BIT=1 cnt never leaves 0, so bit_end simply follows run
    assign bit_end = run && (cnt == CW'(CLKS_PER_BIT - 1));
    always_ff @(posedge clk)
        cnt <= (rst || !run || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lvds_serial_tx.sv
// lvds_serial_tx: async frame transmitter (start, W payload bits LSB first, [parity], stop bits; idles high).
//   Ports: clk, rst (sync, active high), bus (slave modport: data_in, tx_ena in; tx, tx_busy, tx_done out).
//   Define LVDS_TX_PARITY_EN to add one parity bit after the payload (PARITY_ODD selects odd sense).
module lvds_serial_tx
    import lvds_serial_tx_pkg::*;
#(
    parameter int CH_NUM       = LVDS_CH_NUM,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input logic clk,
    input logic rst,
    lvds_serial_tx_if.slave bus
);
    localparam int W  = CH_NUM * DATA_W;
    localparam int BW = $clog2(W + 1);
    lvds_state_e state, state_n;
    logic [W-1:0]  sft, sft_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic          stop_cnt, stop_cnt_n;
    logic          tx_q, tx_n;
    logic          done_q, done_n;
    logic          bit_end;
`ifdef LVDS_TX_PARITY_EN
    logic          acc, acc_n;
`endif
    lvds_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state != ST_IDLE),
        .bit_end (bit_end)
    );
    assign bus.tx      = tx_q;
    assign bus.tx_done = done_q;
    // lets upstream drop tx_ena as soon as the accept edge is guaranteed
    assign bus.tx_busy = rst | bus.tx_ena | (state != ST_IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sft      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= LVDS_IDLE_LVL;
            done_q   <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
            acc      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            sft      <= sft_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
`ifdef LVDS_TX_PARITY_EN
            acc      <= acc_n;
`endif
        end
    end
    always_comb begin
        state_n    = state;
        sft_n      = sft;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        tx_n       = tx_q;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: if (bus.tx_ena) begin
                sft_n   = bus.data_in;
                tx_n    = LVDS_START_LVL;
                state_n = ST_START;
            end
            ST_START: if (bit_end) begin
                tx_n      = sft[0];
                sft_n     = sft >> 1;
                bit_cnt_n = '0;
                state_n   = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                if (bit_cnt == BW'(W - 1)) begin
                    stop_cnt_n = 1'b0;
`ifdef LVDS_TX_PARITY_EN
                    tx_n    = acc ^ 1'(PARITY_ODD);
                    state_n = ST_PARITY;
`else
                    tx_n    = LVDS_IDLE_LVL;
                    state_n = ST_STOP;
`endif
                end else begin
                    tx_n      = sft[0];
                    sft_n     = sft >> 1;
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
`ifdef LVDS_TX_PARITY_EN
            ST_PARITY: if (bit_end) begin
                tx_n    = LVDS_IDLE_LVL;
                state_n = ST_STOP;
            end
`endif
            ST_STOP: if (bit_end) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    stop_cnt_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef LVDS_TX_PARITY_EN
        // acc folds in each bit as it leaves the shifter; the shifter is all zeros by the last data bit
        acc_n = (state == ST_IDLE) ? 1'b0
              : (bit_end && (state == ST_START || state == ST_DATA)) ? acc ^ sft[0] : acc;
`endif
    end
endmodule
